// File: rtl/kpn_fifo_param.sv
// Parameterised synchronous FIFO for KPN channels with registered read data and status flags.
// Optional sticky overflow/underflow flags are enabled with the KPN_FIFO_ERR_EN macro.
module kpn_fifo_param #(
    parameter int DATA_WIDTH      = 16,
    parameter int DEPTH           = 8,
    parameter int ALMOST_FULL_TH  = DEPTH - 1,
    parameter int ALMOST_EMPTY_TH = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr,
    input  logic                    rd,
    input  logic [DATA_WIDTH-1:0]   entry_1,
    output logic [DATA_WIDTH-1:0]   output_1,
    output logic                    valid_1,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  rd_ok;
    logic                  wr_ok;
    logic [CW-1:0]         count_next;

    // A write into a full FIFO is allowed when a read frees a slot on the same edge.
    always_comb begin
        rd_ok      = rd & ~empty;
        wr_ok      = wr & (~full | rd_ok);
        count_next = count;
        if (wr_ok && !rd_ok) begin
            count_next = count + CW'(1);
        end else if (rd_ok && !wr_ok) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            output_1     <= '0;
            valid_1      <= 1'b0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr   <= rd_ptr + AW'(1);
                output_1 <= mem[rd_ptr];
            end
            valid_1      <= rd_ok;
            count        <= count_next;
            // Flags are derived from the next count so they always agree with count.
            empty        <= (count_next == '0);
            full         <= (count_next == CW'(DEPTH));
            almost_full  <= (int'(count_next) >= ALMOST_FULL_TH);
            almost_empty <= (int'(count_next) <= ALMOST_EMPTY_TH);
        end
    end

    // Storage is deliberately left unreset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= entry_1;
        end
    end

`ifdef KPN_FIFO_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr && !wr_ok) begin
                overflow <= 1'b1;
            end
            if (rd && !rd_ok) begin
                underflow <= 1'b1;
            end
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_kpn_fifo_param.sv
// Self-checking bench for kpn_fifo_param: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_kpn_fifo_param;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int AF_TH = 3;
    localparam int AE_TH = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          wr = 1'b0;
    logic          rd = 1'b0;
    logic [DW-1:0] entry_1 = '0;
    logic [DW-1:0] output_1;
    logic          valid_1;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [2:0]    count;
    logic          overflow;
    logic          underflow;

    kpn_fifo_param #(
        .DATA_WIDTH     (DW),
        .DEPTH          (DEPTH),
        .ALMOST_FULL_TH (AF_TH),
        .ALMOST_EMPTY_TH(AE_TH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr          (wr),
        .rd          (rd),
        .entry_1     (entry_1),
        .output_1    (output_1),
        .valid_1     (valid_1),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    // Reference model state: the FIFO contents as a queue plus the observable side effects.
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_out = '0;
    logic          exp_valid = 1'b0;
    logic          exp_ovf = 1'b0;
    logic          exp_unf = 1'b0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput();
        int n;
        n = model_q.size();
        check("count", 32'(count), 32'(n));
        check("empty", 32'(empty), 32'(n == 0));
        check("full", 32'(full), 32'(n == DEPTH));
        check("almost_full", 32'(almost_full), 32'(n >= AF_TH));
        check("almost_empty", 32'(almost_empty), 32'(n <= AE_TH));
        check("valid_1", 32'(valid_1), 32'(exp_valid));
        check("output_1", 32'(output_1), 32'(exp_out));
`ifdef KPN_FIFO_ERR_EN
        check("overflow", 32'(overflow), 32'(exp_ovf));
        check("underflow", 32'(underflow), 32'(exp_unf));
`else
        check("overflow", 32'(overflow), 32'h0);
        check("underflow", 32'(underflow), 32'h0);
`endif
    endtask

    // One clock cycle: drive on the falling edge, update the model, check just after the rising edge.
    task automatic applyStimulus(input logic w, input logic r, input logic [DW-1:0] d);
        bit rd_take;
        bit wr_take;
        @(negedge clk);
        wr      = w;
        rd      = r;
        entry_1 = d;
        rd_take = r && (model_q.size() != 0);
        wr_take = w && ((model_q.size() != DEPTH) || rd_take);
        if (w && !wr_take) exp_ovf = 1'b1;
        if (r && !rd_take) exp_unf = 1'b1;
        exp_valid = rd_take;
        if (rd_take) exp_out = model_q.pop_front();
        if (wr_take) model_q.push_back(d);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic modelReset();
        model_q.delete();
        exp_out   = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;
    endtask

    initial begin
        // Power-on reset, checked before any clock edge.
        #1 rst_n = 1'b0;
        #2;
        modelReset();
        checkOutput();
        #4 rst_n = 1'b1;

        // Three tokens in, three out.
        applyStimulus(1, 0, 16'd10);
        applyStimulus(1, 0, 16'd20);
        applyStimulus(1, 0, 16'd30);
        applyStimulus(0, 1, 16'd0);
        applyStimulus(0, 1, 16'd0);
        applyStimulus(0, 1, 16'd0);
        applyStimulus(0, 0, 16'd0);

        // Overfill: fifth write rejected, then drain.
        for (int i = 1; i <= 5; i++) applyStimulus(1, 0, DW'(i));
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 16'd0);

        // Simultaneous read and write while full.
        for (int i = 1; i <= 4; i++) applyStimulus(1, 0, DW'(40 + i));
        applyStimulus(1, 1, 16'd99);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 16'd0);

        // Simultaneous read and write while empty: no fall-through.
        applyStimulus(1, 1, 16'd7);
        applyStimulus(0, 1, 16'd0);
        applyStimulus(0, 0, 16'd0);

        // Stream across several pointer wraps with occupancy kept small.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 0, DW'(i));
            applyStimulus(1, 1, DW'(100 + i));
            applyStimulus(0, 1, 16'd0);
        end
        while (model_q.size() != 0) applyStimulus(0, 1, 16'd0);

        // Asynchronous reset pulse between edges discards stored tokens.
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, DW'(200 + i));
        #1 rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput();
        #1 rst_n = 1'b1;
        applyStimulus(0, 1, 16'd0);

        // Random traffic with slowly varying write/read bias to visit full and empty often.
        for (int i = 0; i < 400; i++) begin
            int wp;
            int rp;
            wp = ((i / 50) % 2 == 0) ? 70 : 30;
            rp = 100 - wp;
            applyStimulus($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, DW'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
